// File: rtl/shift_register_8b.sv
// -----------------------------------------------------------------------------
// shift_register_8b
//
// Universal shift register: parallel load, bidirectional serial shift, a
// registered serial output and the full register contents as a parallel
// output. Typically used as a serializer/deserializer stage.
//
// Parameters:
//   WIDTH      register width in bits (default 8)
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      synchronous, active-high; clears state and serialOut
//   parallelIn parallel load data, taken when mode=1
//   serialIn   bit entering the vacated end during a shift
//   mode       1 = parallel load, 0 = shift
//   dir        0 = shift right (toward bit 0), 1 = shift left (toward MSB)
//   serialOut  registered copy of the bit most recently shifted out
//   state      current register contents
//
// Per-edge priority is reset > load > shift. Every cycle with mode=0 is a
// shift; there is no hold. Both outputs come straight from flops.
// -----------------------------------------------------------------------------
module shift_register_8b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallelIn,
  input  logic             serialIn,
  input  logic             mode,
  input  logic             dir,
  output logic             serialOut,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_p0;
  logic             sout_p0;

  // Next register contents for a shift. The exiting bit is not wrapped around;
  // it is captured separately into the serial output flop.
  function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] cur,
                                                  input logic             left,
                                                  input logic             sin);
    if (left) begin
      return {cur[WIDTH-2:0], sin};
    end
    return {sin, cur[WIDTH-1:1]};
  endfunction

  // Bit leaving the register for a shift in the given direction.
  function automatic logic exit_bit(input logic [WIDTH-1:0] cur,
                                    input logic             left);
    return left ? cur[WIDTH-1] : cur[0];
  endfunction

  // Stage p0: the only register stage; outputs are taken from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= '0;
      sout_p0  <= 1'b0;
    end else if (mode) begin
      // Load leaves the serial output untouched.
      state_p0 <= parallelIn;
    end else begin
      state_p0 <= shift_next(state_p0, dir, serialIn);
      sout_p0  <= exit_bit(state_p0, dir);
    end
  end

  assign state     = state_p0;
  assign serialOut = sout_p0;

endmodule

// File: tb/tb_shift_register_8b.sv
module tb_shift_register_8b;

  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         reset;
  logic [W-1:0] parallelIn;
  logic         serialIn;
  logic         mode;
  logic         dir;
  logic         serialOut;
  logic [W-1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register as an integer, shifts as arithmetic.
  int m_state = 0;
  int m_out   = 0;

  shift_register_8b #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .parallelIn (parallelIn),
    .serialIn   (serialIn),
    .mode       (mode),
    .dir        (dir),
    .serialOut  (serialOut),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let one rising edge happen, advance the model,
  // and return #1 after the edge so outputs can be sampled.
  task automatic step(input logic r, input logic md, input logic d,
                      input logic si, input logic [W-1:0] p);
    reset = r; mode = md; dir = d; serialIn = si; parallelIn = p;
    @(posedge clk);
    if (r) begin
      m_state = 0;
      m_out   = 0;
    end else if (md) begin
      m_state = int'(p);
    end else if (!d) begin
      m_out   = m_state % 2;
      m_state = (m_state / 2) + (int'(si) * (1 << (W - 1)));
    end else begin
      m_out   = (m_state / (1 << (W - 1))) % 2;
      m_state = ((m_state * 2) & MASK) + int'(si);
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    n_checks++;
    if (state !== 8'h00 || serialOut !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clear: state=%h serialOut=%b required state=00 serialOut=0", state, serialOut);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    n_checks++;
    if (state !== 8'h00 || serialOut !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_over_load: state=%h serialOut=%b required state=00 serialOut=0", state, serialOut);
    end
    // Reset released with mode=1: load happens on that same edge.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
    n_checks++;
    if (state !== 8'h3C || serialOut !== 1'b0) begin
      n_fail++;
      $display("FAIL load_after_reset: state=%h serialOut=%b required state=3c serialOut=0", state, serialOut);
    end
  endtask

  task automatic test_shift_right();
    logic [W-1:0] exp_s [0:8];
    logic         exp_o [0:8];
    exp_s = '{8'h04, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_o = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h09);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if (state !== exp_s[i] || serialOut !== exp_o[i]) begin
        n_fail++;
        $display("FAIL shift_right[%0d]: state=%h serialOut=%b required state=%h serialOut=%b",
                 i, state, serialOut, exp_s[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_shift_left();
    logic [W-1:0] exp_s [0:8];
    logic         exp_o [0:8];
    exp_s = '{8'h38, 8'h70, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h1C);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      n_checks++;
      if (state !== exp_s[i] || serialOut !== exp_o[i]) begin
        n_fail++;
        $display("FAIL shift_left[%0d]: state=%h serialOut=%b required state=%h serialOut=%b",
                 i, state, serialOut, exp_s[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_serial_fill();
    for (int d = 0; d < 2; d++) begin
      int so_bad;
      so_bad = 0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < W; i++) begin
        step(1'b0, 1'b0, d[0], 1'b1, 8'h00);
        if (serialOut !== 1'b0) so_bad++;
      end
      n_checks++;
      if (state !== 8'hFF || so_bad != 0) begin
        n_fail++;
        $display("FAIL serial_fill dir=%0d: state=%h serialOut_nonzero=%0d required state=ff serialOut_nonzero=0",
                 d, state, so_bad);
      end
    end
  endtask

  task automatic test_dir_change();
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h81);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if (state !== 8'h40 || serialOut !== 1'b1) begin
      n_fail++;
      $display("FAIL dir_change_right: state=%h serialOut=%b required state=40 serialOut=1", state, serialOut);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    n_checks++;
    if (state !== 8'h80 || serialOut !== 1'b0) begin
      n_fail++;
      $display("FAIL dir_change_left: state=%h serialOut=%b required state=80 serialOut=0", state, serialOut);
    end
  endtask

  task automatic test_priority();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);  // -> 80, serialOut=1
    n_checks++;
    if (state !== 8'h80 || serialOut !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_setup: state=%h serialOut=%b required state=80 serialOut=1", state, serialOut);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
    n_checks++;
    if (state !== 8'hA5 || serialOut !== 1'b1) begin
      n_fail++;
      $display("FAIL load_mid_shift: state=%h serialOut=%b required state=a5 serialOut=1", state, serialOut);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);  // -> 52, serialOut=1
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    n_checks++;
    if (state !== 8'h00 || serialOut !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_shift: state=%h serialOut=%b required state=00 serialOut=0", state, serialOut);
    end
  endtask

  task automatic test_random();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      logic r, md, d, si;
      logic [W-1:0] p;
      r  = ($urandom_range(0, 19) == 0);
      md = ($urandom_range(0, 4) == 0);
      d  = $urandom_range(0, 1);
      si = $urandom_range(0, 1);
      p  = W'($urandom);
      step(r, md, d, si, p);
      n_checks++;
      if (int'(state) != m_state || int'(serialOut) != m_out) begin
        n_fail++;
        $display("FAIL random[%0d]: state=%h serialOut=%b required state=%h serialOut=%0d",
                 i, state, serialOut, m_state[W-1:0], m_out);
      end
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; dir = 1'b0; serialIn = 1'b0; parallelIn = '0;
    test_reset();
    test_shift_right();
    test_shift_left();
    test_serial_fill();
    test_dir_change();
    test_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
